// File: rtl/ex_cond_stage.sv
// Execute-stage condition check and EX/MEM pipeline register.
// Gates EX writes on the condition result and holds the architectural NZCV flags.
module ex_cond_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallM,
  input  logic        FlushE,
  input  logic [3:0]  CondE,
  input  logic [1:0]  FlagWriteE,
  input  logic [3:0]  ALUFlags,
  input  logic [31:0] ALUResultE,
  input  logic [31:0] WriteDataE,
  input  logic [3:0]  WA3E,
  input  logic        RegWriteE,
  input  logic        MemWriteE,
  input  logic        MemtoRegE,
  input  logic        PCSrcE,
  input  logic        BranchE,
  output logic        CondExE,
  output logic        BranchTakenE,
  output logic [3:0]  Flags,
  output logic [31:0] ALUOutM,
  output logic [31:0] WriteDataM,
  output logic [3:0]  WA3M,
  output logic        RegWriteM,
  output logic        MemWriteM,
  output logic        MemtoRegM,
  output logic        PCSrcM
);

  logic [3:0]  flags_q, flags_d;
  logic [31:0] alu_out_q, alu_out_d;
  logic [31:0] write_data_q, write_data_d;
  logic [3:0]  wa3_q, wa3_d;
  logic        reg_write_q, reg_write_d;
  logic        mem_write_q, mem_write_d;
  logic        mem_to_reg_q, mem_to_reg_d;
  logic        pc_src_q, pc_src_d;

  logic n_flag, z_flag, c_flag, v_flag;
  logic cond_ex;

  assign {n_flag, z_flag, c_flag, v_flag} = flags_q;

  // Condition is evaluated against the flags before this instruction's own update.
  always_comb begin
    cond_ex = 1'b0;
    case (CondE)
      4'b0000: cond_ex = z_flag;
      4'b0001: cond_ex = ~z_flag;
      4'b0010: cond_ex = c_flag;
      4'b0011: cond_ex = ~c_flag;
      4'b0100: cond_ex = n_flag;
      4'b0101: cond_ex = ~n_flag;
      4'b0110: cond_ex = v_flag;
      4'b0111: cond_ex = ~v_flag;
      4'b1000: cond_ex = c_flag & ~z_flag;
      4'b1001: cond_ex = ~c_flag | z_flag;
      4'b1010: cond_ex = (n_flag == v_flag);
      4'b1011: cond_ex = (n_flag != v_flag);
      4'b1100: cond_ex = ~z_flag & (n_flag == v_flag);
      4'b1101: cond_ex = z_flag | (n_flag != v_flag);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;  // 1111 is unsupported and never executes
    endcase
  end

  assign CondExE      = cond_ex;
  assign BranchTakenE = BranchE & cond_ex & ~FlushE;

  // Flush beats stall: a killed instruction becomes a bubble even while MEM is stalled.
  always_comb begin
    flags_d      = flags_q;
    alu_out_d    = alu_out_q;
    write_data_d = write_data_q;
    wa3_d        = wa3_q;
    reg_write_d  = reg_write_q;
    mem_write_d  = mem_write_q;
    mem_to_reg_d = mem_to_reg_q;
    pc_src_d     = pc_src_q;
    if (FlushE) begin
      alu_out_d    = ALUResultE;
      write_data_d = WriteDataE;
      wa3_d        = WA3E;
      reg_write_d  = 1'b0;
      mem_write_d  = 1'b0;
      mem_to_reg_d = 1'b0;
      pc_src_d     = 1'b0;
    end else if (!StallM) begin
      alu_out_d    = ALUResultE;
      write_data_d = WriteDataE;
      wa3_d        = WA3E;
      reg_write_d  = RegWriteE & cond_ex;
      mem_write_d  = MemWriteE & cond_ex;
      mem_to_reg_d = MemtoRegE;
      pc_src_d     = PCSrcE & cond_ex;
      if (FlagWriteE[1] & cond_ex) begin
        flags_d[3:2] = ALUFlags[3:2];
      end
      if (FlagWriteE[0] & cond_ex) begin
        flags_d[1:0] = ALUFlags[1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q      <= 4'b0000;
      alu_out_q    <= 32'h0;
      write_data_q <= 32'h0;
      wa3_q        <= 4'h0;
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      pc_src_q     <= 1'b0;
    end else begin
      flags_q      <= flags_d;
      alu_out_q    <= alu_out_d;
      write_data_q <= write_data_d;
      wa3_q        <= wa3_d;
      reg_write_q  <= reg_write_d;
      mem_write_q  <= mem_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      pc_src_q     <= pc_src_d;
    end
  end

  assign Flags      = flags_q;
  assign ALUOutM    = alu_out_q;
  assign WriteDataM = write_data_q;
  assign WA3M       = wa3_q;
  assign RegWriteM  = reg_write_q;
  assign MemWriteM  = mem_write_q;
  assign MemtoRegM  = mem_to_reg_q;
  assign PCSrcM     = pc_src_q;

endmodule

// File: tb/tb_ex_cond_stage.sv
// Scoreboard bench for ex_cond_stage: a reference model predicts M-stage state per cycle.
module tb_ex_cond_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        StallM, FlushE;
  logic [3:0]  CondE;
  logic [1:0]  FlagWriteE;
  logic [3:0]  ALUFlags;
  logic [31:0] ALUResultE, WriteDataE;
  logic [3:0]  WA3E;
  logic        RegWriteE, MemWriteE, MemtoRegE, PCSrcE, BranchE;
  logic        CondExE, BranchTakenE;
  logic [3:0]  Flags;
  logic [31:0] ALUOutM, WriteDataM;
  logic [3:0]  WA3M;
  logic        RegWriteM, MemWriteM, MemtoRegM, PCSrcM;

  ex_cond_stage dut (
    .clk          (clk),
    .reset        (reset),
    .StallM       (StallM),
    .FlushE       (FlushE),
    .CondE        (CondE),
    .FlagWriteE   (FlagWriteE),
    .ALUFlags     (ALUFlags),
    .ALUResultE   (ALUResultE),
    .WriteDataE   (WriteDataE),
    .WA3E         (WA3E),
    .RegWriteE    (RegWriteE),
    .MemWriteE    (MemWriteE),
    .MemtoRegE    (MemtoRegE),
    .PCSrcE       (PCSrcE),
    .BranchE      (BranchE),
    .CondExE      (CondExE),
    .BranchTakenE (BranchTakenE),
    .Flags        (Flags),
    .ALUOutM      (ALUOutM),
    .WriteDataM   (WriteDataM),
    .WA3M         (WA3M),
    .RegWriteM    (RegWriteM),
    .MemWriteM    (MemWriteM),
    .MemtoRegM    (MemtoRegM),
    .PCSrcM       (PCSrcM)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  flags;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [3:0]  wa;
    logic        rw, mw, m2r, pcs;
  } mstate_t;

  mstate_t sb_q[$];
  mstate_t mdl;
  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic cond_model(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic idle_inputs();
    StallM = 0; FlushE = 0; CondE = 4'he; FlagWriteE = 0; ALUFlags = 0;
    ALUResultE = 0; WriteDataE = 0; WA3E = 0;
    RegWriteE = 0; MemWriteE = 0; MemtoRegE = 0; PCSrcE = 0; BranchE = 0;
  endtask

  // Entered just after a rising edge with inputs already applied.
  task automatic run_cycle();
    mstate_t e;
    logic c;
    @(negedge clk);
    c = cond_model(CondE, mdl.flags);
    check_val("condex", {31'b0, CondExE}, {31'b0, c});
    check_val("brtaken", {31'b0, BranchTakenE}, {31'b0, BranchE & c & ~FlushE});
    e = mdl;
    if (FlushE) begin
      e.alu = ALUResultE; e.wd = WriteDataE; e.wa = WA3E;
      e.rw = 0; e.mw = 0; e.m2r = 0; e.pcs = 0;
    end else if (!StallM) begin
      e.alu = ALUResultE; e.wd = WriteDataE; e.wa = WA3E;
      e.rw = RegWriteE & c; e.mw = MemWriteE & c; e.m2r = MemtoRegE; e.pcs = PCSrcE & c;
      if (FlagWriteE[1] && c) e.flags[3:2] = ALUFlags[3:2];
      if (FlagWriteE[0] && c) e.flags[1:0] = ALUFlags[1:0];
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check_val("flags", {28'b0, Flags}, {28'b0, e.flags});
    check_val("aluoutm", ALUOutM, e.alu);
    check_val("wdatam", WriteDataM, e.wd);
    check_val("wa3m", {28'b0, WA3M}, {28'b0, e.wa});
    check_val("ctrlm", {28'b0, RegWriteM, MemWriteM, MemtoRegM, PCSrcM},
              {28'b0, e.rw, e.mw, e.m2r, e.pcs});
    mdl = e;
  endtask

  task automatic set_flags(input logic [3:0] f);
    idle_inputs();
    FlagWriteE = 2'b11; ALUFlags = f;
    run_cycle();
  endtask

  task automatic probe_cond(input string tag, input logic [3:0] c, input logic exp);
    idle_inputs();
    CondE = c;
    #1;
    check_val(tag, {31'b0, CondExE}, {31'b0, exp});
    run_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    mdl = '0;
    idle_inputs();
    reset = 1;
    @(posedge clk); @(posedge clk); #1;
    check_val("rst_flags", {28'b0, Flags}, 32'h0);
    check_val("rst_aluout", ALUOutM, 32'h0);
    check_val("rst_ctrl", {28'b0, RegWriteM, MemWriteM, MemtoRegM, PCSrcM}, 32'h0);
    CondE = 4'b0000;
    #1;
    check_val("rst_eq", {31'b0, CondExE}, 32'h0);
    reset = 0;
    @(posedge clk); #1;

    // Flag update then dependent consumers
    idle_inputs();
    FlagWriteE = 2'b11; ALUFlags = 4'b0100; RegWriteE = 1; ALUResultE = 32'h11; WA3E = 4'd3;
    run_cycle();
    check_val("subs_flags", {28'b0, Flags}, 32'h4);
    idle_inputs();
    CondE = 4'b0000; RegWriteE = 1; ALUResultE = 32'h22; WA3E = 4'd5;
    run_cycle();
    check_val("eq_rw", {31'b0, RegWriteM}, 32'h1);
    idle_inputs();
    CondE = 4'b0001; RegWriteE = 1; ALUResultE = 32'h33; WA3E = 4'd6;
    run_cycle();
    check_val("ne_rw", {31'b0, RegWriteM}, 32'h0);
    check_val("ne_wa3", {28'b0, WA3M}, 32'h6);

    // Partial write keeps C,V
    set_flags(4'b1010);
    idle_inputs();
    FlagWriteE = 2'b10; ALUFlags = 4'b0101;
    run_cycle();
    check_val("partial", {28'b0, Flags}, 32'h6);

    // Signed and unsigned conditions
    set_flags(4'b1001);
    probe_cond("ge_1001", 4'b1010, 1);
    probe_cond("lt_1001", 4'b1011, 0);
    probe_cond("gt_1001", 4'b1100, 1);
    probe_cond("le_1001", 4'b1101, 0);
    set_flags(4'b1000);
    probe_cond("ge_1000", 4'b1010, 0);
    probe_cond("lt_1000", 4'b1011, 1);
    probe_cond("le_1000", 4'b1101, 1);
    set_flags(4'b0010);
    probe_cond("hi_0010", 4'b1000, 1);
    set_flags(4'b0110);
    probe_cond("ls_0110", 4'b1001, 1);
    probe_cond("nv_0110", 4'b1111, 0);

    // Stall holds everything, including flags
    idle_inputs();
    RegWriteE = 1; MemWriteE = 1; ALUResultE = 32'hCAFE; WriteDataE = 32'hBEEF; WA3E = 4'd9;
    run_cycle();
    for (int i = 0; i < 3; i++) begin
      idle_inputs();
      StallM = 1; FlagWriteE = 2'b11; ALUFlags = 4'b1111;
      ALUResultE = 32'h1234 + i; WA3E = 4'd1;
      run_cycle();
    end
    check_val("stall_flags", {28'b0, Flags}, 32'h6);
    check_val("stall_alu", ALUOutM, 32'hCAFE);
    // Flush overrides stall
    idle_inputs();
    StallM = 1; FlushE = 1; BranchE = 1; RegWriteE = 1; MemWriteE = 1; PCSrcE = 1;
    FlagWriteE = 2'b11; ALUFlags = 4'b1111;
    #1;
    check_val("flush_br", {31'b0, BranchTakenE}, 32'h0);
    run_cycle();
    check_val("flush_ctrl", {29'b0, RegWriteM, MemWriteM, PCSrcM}, 32'h0);
    check_val("flush_flags", {28'b0, Flags}, 32'h6);

    // Branches
    set_flags(4'b0100);
    idle_inputs();
    CondE = 4'b0000; BranchE = 1; PCSrcE = 1;
    #1;
    check_val("br_taken", {31'b0, BranchTakenE}, 32'h1);
    run_cycle();
    set_flags(4'b0000);
    idle_inputs();
    CondE = 4'b0000; BranchE = 1; PCSrcE = 1;
    #1;
    check_val("br_not", {31'b0, BranchTakenE}, 32'h0);
    run_cycle();
    check_val("br_pcsrc", {31'b0, PCSrcM}, 32'h0);

    // Random traffic
    for (int i = 0; i < 200; i++) begin
      StallM = ($urandom_range(0, 4) == 0);
      FlushE = ($urandom_range(0, 7) == 0);
      CondE = 4'($urandom); FlagWriteE = 2'($urandom); ALUFlags = 4'($urandom);
      ALUResultE = $urandom; WriteDataE = $urandom; WA3E = 4'($urandom);
      RegWriteE = 1'($urandom); MemWriteE = 1'($urandom); MemtoRegE = 1'($urandom);
      PCSrcE = 1'($urandom); BranchE = 1'($urandom);
      run_cycle();
    end

    // Asynchronous reset mid-stall with flags all set
    set_flags(4'b1111);
    idle_inputs();
    RegWriteE = 1; ALUResultE = 32'h77;
    run_cycle();
    idle_inputs();
    StallM = 1;
    #2;
    reset = 1;
    #1;
    check_val("arst_flags", {28'b0, Flags}, 32'h0);
    check_val("arst_rw", {31'b0, RegWriteM}, 32'h0);
    check_val("arst_alu", ALUOutM, 32'h0);
    mdl = '0;
    @(posedge clk); #1;
    reset = 0;
    idle_inputs();
    RegWriteE = 1; ALUResultE = 32'h88; WA3E = 4'd2;
    run_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ex_cond_stage.md
# ex_cond_stage

Execute-stage condition unit and EX/MEM pipeline register for the 5-stage ARM pipeline. It sits directly downstream of the ALU. It evaluates the EX instruction's condition field against the architectural NZCV flags, then gates the instruction's register, memory and PC writes on that result. It updates the flags register from the ALU's ALUFlags and registers everything the MEM stage needs.

## Interface
Parameters: none (datapath fixed at 32 bits, register address 4 bits). Ports, with clock and reset first:
- clk  in  1  pipeline clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-high; clears all state
- StallM  in  1  MEM not ready; the EX/MEM register and flags hold
- FlushE  in  1  kill the instruction currently in EX; it must not reach MEM
- CondE  in  4  instruction condition field [31:28]
- FlagWriteE  in  2  [1] enables the N,Z update; [0] enables the C,V update
- ALUFlags  in  4  {N,Z,C,V} from the ALU for the current EX instruction
- ALUResultE  in  32  ALU Result
- WriteDataE  in  32  store data (forwarded Rd)
- WA3E  in  4  destination register
- RegWriteE, MemWriteE, MemtoRegE, PCSrcE, BranchE  in  1 each  decoded controls (pre-condition)
- CondExE  out  1  combinational; condition passed
- BranchTakenE  out  1  combinational; BranchE & CondExE & ~FlushE (to fetch redirect)
- Flags  out  4  registered architectural {N,Z,C,V}
- ALUOutM, WriteDataM  out  32 each  registered
- WA3M  out  4  registered
- RegWriteM, MemWriteM, MemtoRegM, PCSrcM  out  1 each  registered, condition-gated

## Operation
- Condition evaluation uses the current Flags register, i.e. the flags before the EX instruction's own update. The encodings are:
  - 0000 EQ: Z; 0001 NE: ~Z; 0010 CS: C; 0011 CC: ~C
  - 0100 MI: N; 0101 PL: ~N; 0110 VS: V; 0111 VC: ~V
  - 1000 HI: C&~Z; 1001 LS: ~C|Z
  - 1010 GE: N==V; 1011 LT: N!=V
  - 1100 GT: ~Z&(N==V); 1101 LE: Z|(N!=V)
  - 1110 AL: 1; 1111: 0 (unsupported, treated as never)
- Write gating: RegWriteM_next = RegWriteE&CondExE, and likewise for MemWriteM and PCSrcM. MemtoRegM, ALUOutM, WriteDataM and WA3M pass ungated.
- The instruction advances when ~StallM & ~FlushE. Only on an advancing edge:
  - Flags[3:2] <= ALUFlags[3:2] if FlagWriteE[1]&CondExE
  - Flags[1:0] <= ALUFlags[1:0] if FlagWriteE[0]&CondExE
- Failed condition: no flag change, no register, memory or PC write, but the bubble still carries ALUOutM and WA3M.

## Timing
- Reset (asynchronous, immediate): Flags=0000, all M-stage outputs 0 (ALUOutM=0, WriteDataM=0, WA3M=0, all control bits 0). CondExE and BranchTakenE then follow the combinational inputs against Flags=0000.
- Latency: 1 cycle, E inputs to M outputs. Flags become visible to the next instruction's CondExE one cycle after the update. There is no internal bypass; back-to-back flag dependencies are correct because the consumer enters EX on the following cycle.
- Edge priority is FlushE > StallM > advance:
  - FlushE=1: the M-stage control bits (RegWriteM, MemWriteM, MemtoRegM, PCSrcM) load 0, the data fields load don't-care (implement as load), Flags hold. This applies regardless of StallM.
  - StallM=1, FlushE=0: all M outputs and Flags hold their values.
- FlushE forces BranchTakenE=0 in the same cycle.
- Reset asserted mid-stall or mid-flush: reset wins immediately. On the first edge after deassertion, normal priority applies.
- ALUFlags are consumed exactly as delivered by the ALU: V and C are meaningful only for add/sub. Gating for logical ops is the decoder's responsibility via FlagWriteE.

## Test plan
- **Reset/flags:** assert reset mid-cycle with Flags=1111 -> Flags=0000 and RegWriteM=0 before the next edge. With CondE=0000 and Flags=0000 -> CondExE=0.
- **Flag update:** CondE=1110, FlagWriteE=11, ALUFlags=0100 (SUBS equal operands) -> after 1 edge Flags=0100. The next instruction with CondE=0000 sees CondExE=1; one with CondE=0001 sees CondExE=0 and RegWriteM=0 after its edge.
- **Partial write:** Flags=1010, FlagWriteE=10, ALUFlags=0101 -> Flags=0110 (C,V unchanged).
- **Signed conditions:** Flags=1001 -> GE=1, LT=0, GT=1, LE=0. Flags=1000 -> GE=0, LT=1, LE=1. Flags=0010 -> HI=1. Flags=0110 -> LS=1.
- **Stall/flush:** StallM=1 for 3 cycles with FlagWriteE=11 -> Flags and M outputs unchanged. StallM=1 & FlushE=1 -> RegWriteM=MemWriteM=PCSrcM=0, Flags unchanged, BranchTakenE=0.
- **Branch:** BranchE=1, CondE=0000, Flags=0100 -> BranchTakenE=1 in the same cycle. With Flags=0000 -> BranchTakenE=0 and PCSrcM=0.
